pipe_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order RISC-V pipeline.

---
 rtl/pipe_hazard_unit.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks DEPTH in-flight instructions past decode (entry 1 = EX, DEPTH = WB).
// It raises load-use stalls, redirect flushes and a freeze while data memory
// is busy. It also picks EX operand forward sources and counts stall cycles.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   id_*                         decode-stage instruction description
//   ex_redirect                  taken branch/jump resolved in EX
//   mem_busy                     data memory wait, whole pipe holds
//   stall_f, flush_id, bubble_ex front-end hold / IF-ID flush / ID-EX bubble
//   freeze                       all pipeline registers hold
//   fwd_rs1_sel, fwd_rs2_sel     0 = ID/EX value, k = result of stage k
//   perf_stall_cnt               saturating count of load-use stall cycles
module pipe_hazard_unit #(
  parameter int unsigned RA_W       = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 3,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_f,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [SEL_W-1:0] fwd_rs1_sel,
  output logic [SEL_W-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  logic [DEPTH:1]           s_valid;
  logic [DEPTH:1]           s_we;
  logic [DEPTH:1]           s_load;
  logic [DEPTH:1][RA_W-1:0] s_rd;
  logic [RA_W-1:0]          ex_rs1;
  logic [RA_W-1:0]          ex_rs2;
  logic                     ex_rs1_used;
  logic                     ex_rs2_used;
  logic [CNT_W-1:0]         stall_cnt;

  logic [DEPTH:1] m_id1, m_id2, m_ex1, m_ex2;
  logic           hazard;
  logic           take_id;

  // Youngest matching producer decides; a load hazards if its result is
  // not yet forwardable when the consumer needs it (lead = 1 for EX use,
  // 2 for store data consumed one stage later in MEM).
  function automatic logic load_hazard(input logic [DEPTH:1] m,
                                       input logic [DEPTH:1] ld,
                                       input int unsigned    lead);
    logic hit;
    logic found;
    hit   = 1'b0;
    found = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found && m[k]) begin
        found = 1'b1;
        hit   = ld[k] && ((k + lead) < LOAD_STAGE);
      end
    end
    return hit;
  endfunction

  // Nearest forwardable producer in stages 2..DEPTH; loads too early are skipped.
  function automatic logic [SEL_W-1:0] fwd_pick(input logic [DEPTH:1] m,
                                                input logic [DEPTH:1] ld,
                                                input logic           used);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int unsigned k = DEPTH; k > 1; k--) begin
      if (used && m[k] && !(ld[k] && (k < LOAD_STAGE))) sel = SEL_W'(k);
    end
    return sel;
  endfunction

  // Register-match vectors against every scoreboard entry; x0 never matches.
  always_comb begin
    logic live;
    m_id1 = '0;
    m_id2 = '0;
    m_ex1 = '0;
    m_ex2 = '0;
    live  = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      live     = s_valid[k] && s_we[k];
      m_id1[k] = live && (s_rd[k] == id_rs1) && (id_rs1 != '0);
      m_id2[k] = live && (s_rd[k] == id_rs2) && (id_rs2 != '0);
      m_ex1[k] = live && (s_rd[k] == ex_rs1) && (ex_rs1 != '0);
      m_ex2[k] = live && (s_rd[k] == ex_rs2) && (ex_rs2 != '0);
    end
  end

  assign hazard = id_valid &&
                  ((id_rs1_used && load_hazard(m_id1, s_load, 1)) ||
                   (id_rs2_used && load_hazard(m_id2, s_load, id_is_store ? 2 : 1)));

  // Pipeline control with priority freeze > redirect > load-use stall.
  always_comb begin
    stall_f   = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = mem_busy;
    if (mem_busy) begin
      stall_f = 1'b1;
    end else if (ex_redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (hazard) begin
      stall_f   = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign fwd_rs1_sel    = fwd_pick(m_ex1, s_load, ex_rs1_used);
  assign fwd_rs2_sel    = fwd_pick(m_ex2, s_load, ex_rs2_used);
  assign perf_stall_cnt = stall_cnt;
  assign take_id        = id_valid && !bubble_ex;

  // Scoreboard advance and stall counter; reset overrides freeze.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_valid     <= '0;
      s_we        <= '0;
      s_load      <= '0;
      s_rd        <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
      stall_cnt   <= '0;
    end else if (!mem_busy) begin
      s_valid     <= {s_valid[DEPTH-1:1], take_id};
      s_we        <= {s_we[DEPTH-1:1], take_id && id_we};
      s_load      <= {s_load[DEPTH-1:1], take_id && id_is_load};
      s_rd        <= {s_rd[DEPTH-1:1], take_id ? id_rd : RA_W'(0)};
      ex_rs1      <= take_id ? id_rs1 : RA_W'(0);
      ex_rs2      <= take_id ? id_rs2 : RA_W'(0);
      ex_rs1_used <= take_id && id_rs1_used;
      ex_rs2_used <= take_id && id_rs2_used;
      if (!ex_redirect && hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  logic       clock;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_we, id_is_load, id_is_store;
  logic       ex_redirect, mem_busy;

  logic       a_stall_f, a_flush_id, a_bubble_ex, a_freeze;
  logic [1:0] a_f1, a_f2;
  logic [31:0] a_cnt;
  logic       b_stall_f, b_flush_id, b_bubble_ex, b_freeze;
  logic [2:0] b_f1, b_f2;
  logic [1:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_unit dut_a (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_f(a_stall_f), .flush_id(a_flush_id), .bubble_ex(a_bubble_ex), .freeze(a_freeze),
    .fwd_rs1_sel(a_f1), .fwd_rs2_sel(a_f2), .perf_stall_cnt(a_cnt)
  );

  pipe_hazard_unit #(.DEPTH(4), .LOAD_STAGE(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_f(b_stall_f), .flush_id(b_flush_id), .bubble_ex(b_bubble_ex), .freeze(b_freeze),
    .fwd_rs1_sel(b_f1), .fwd_rs2_sel(b_f2), .perf_stall_cnt(b_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Directed vector: ID instruction + control inputs, then expected outputs of dut_a.
  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit we; bit ld; bit st;
    bit redir; bit busy; bit rst;
    bit e_stall; bit e_flush; bit e_bub; int e_f1; int e_f2; int e_cnt;
  } vec_t;

  // Reference model: in-flight instruction list, index 1 = EX, youngest first.
  typedef struct packed {
    logic v; logic we; logic ld; logic u1; logic u2;
    logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
  } inst_t;
  typedef inst_t [4:1] pipe_t;

  pipe_t  mp [2];
  longint mcnt [2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int youngest(input pipe_t p, input int d, input logic [4:0] r);
    for (int k = 1; k <= d; k++)
      if (p[k].v && p[k].we && p[k].rd == r && r != 5'd0) return k;
    return 0;
  endfunction

  function automatic int fwd_of(input pipe_t p, input int d, input int ls,
                                input logic [4:0] r, input logic used);
    if (!used || r == 5'd0) return 0;
    for (int k = 2; k <= d; k++)
      if (p[k].v && p[k].we && p[k].rd == r && !(p[k].ld && k < ls)) return k;
    return 0;
  endfunction

  function automatic bit model_hazard(input int c);
    int d = (c == 0) ? 3 : 4;
    int ls = d;
    int k;
    bit h = 1'b0;
    if (!id_valid) return 1'b0;
    if (id_rs1_used) begin
      k = youngest(mp[c], d, id_rs1);
      if (k != 0 && mp[c][k].ld && k + 1 < ls) h = 1'b1;
    end
    if (id_rs2_used) begin
      k = youngest(mp[c], d, id_rs2);
      if (k != 0 && mp[c][k].ld && k + (id_is_store ? 2 : 1) < ls) h = 1'b1;
    end
    return h;
  endfunction

  task automatic model_check(input int c);
    int d = (c == 0) ? 3 : 4;
    bit h = model_hazard(c);
    bit es = mem_busy || (!ex_redirect && h);
    bit ef = !mem_busy && ex_redirect;
    bit eb = !mem_busy && (ex_redirect || h);
    int f1 = fwd_of(mp[c], d, d, mp[c][1].rs1, mp[c][1].u1);
    int f2 = fwd_of(mp[c], d, d, mp[c][1].rs2, mp[c][1].u2);
    string t = (c == 0) ? "model_a" : "model_b";
    if (c == 0) begin
      chk({t, " stall_f"}, a_stall_f, es);   chk({t, " flush_id"}, a_flush_id, ef);
      chk({t, " bubble_ex"}, a_bubble_ex, eb); chk({t, " freeze"}, a_freeze, mem_busy);
      chk({t, " fwd1"}, a_f1, f1);           chk({t, " fwd2"}, a_f2, f2);
      chk({t, " cnt"}, a_cnt, mcnt[c]);
    end else begin
      chk({t, " stall_f"}, b_stall_f, es);   chk({t, " flush_id"}, b_flush_id, ef);
      chk({t, " bubble_ex"}, b_bubble_ex, eb); chk({t, " freeze"}, b_freeze, mem_busy);
      chk({t, " fwd1"}, b_f1, f1);           chk({t, " fwd2"}, b_f2, f2);
      chk({t, " cnt"}, b_cnt, mcnt[c]);
    end
  endtask

  task automatic model_advance(input int c);
    int d = (c == 0) ? 3 : 4;
    longint cmax = (c == 0) ? 64'hFFFF_FFFF : 64'd3;
    bit h = model_hazard(c);
    bit bub = ex_redirect || h;
    inst_t n;
    if (reset) begin
      mp[c] = '0;
      mcnt[c] = 0;
    end else if (!mem_busy) begin
      if (!ex_redirect && h && mcnt[c] < cmax) mcnt[c]++;
      n = '0;
      if (id_valid && !bub)
        n = '{v: 1'b1, we: id_we, ld: id_is_load, u1: id_rs1_used, u2: id_rs2_used,
              rd: id_rd, rs1: id_rs1, rs2: id_rs2};
      for (int k = d; k >= 2; k--) mp[c][k] = mp[c][k-1];
      mp[c][1] = n;
    end
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit we, input bit ld, input bit st,
                       input bit redir, input bit busy, input bit rst);
    id_valid = v;  id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_rs1_used = u1; id_rs2_used = u2; id_rd = 5'(rd);
    id_we = we; id_is_load = ld; id_is_store = st;
    ex_redirect = redir; mem_busy = busy; reset = rst;
  endtask

  // Called just after a negedge with inputs applied; checks then advances one cycle.
  task automatic step();
    #1;
    model_check(0);
    model_check(1);
    model_advance(0);
    model_advance(1);
    @(negedge clock);
  endtask

  function automatic vec_t mk(input bit v, input int rs1, input int rs2, input bit u1,
                              input bit u2, input int rd, input bit we, input bit ld,
                              input bit st, input bit redir, input bit busy, input bit rst,
                              input bit es, input bit ef, input bit eb,
                              input int f1, input int f2, input int cnt);
    vec_t r;
    r = '{v, rs1, rs2, u1, u2, rd, we, ld, st, redir, busy, rst, es, ef, eb, f1, f2, cnt};
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    //          v rs1 rs2 u1 u2 rd we ld st rd bz rs | st fl bu f1 f2 cnt
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // lw x5
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0)); // add x6,x5,x1 stall
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // add released
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1)); // add in EX, fwd WB
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // add x5
    tbl.push_back(mk(1, 5, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // sub x7,x5,x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1)); // sub in EX, fwd MEM
    tbl.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // lw x5
    tbl.push_back(mk(1, 2, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // sw x5,0(x2) no stall
    tbl.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // lw x5
    tbl.push_back(mk(1, 5, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1)); // sw x1,0(x5) stall
    tbl.push_back(mk(1, 5, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // sw released
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2)); // addi x0,x0,1
    tbl.push_back(mk(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // add x3,x0,x0
    tbl.push_back(mk(1, 3, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // lw x5,(x3)
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2)); // nop
    tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // add x6,x5,x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 2)); // nop
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // lw x5
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2)); // redirect wins
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // lw x5
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2)); // frozen
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2)); // frozen
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2)); // frozen
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2)); // stall resumes
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)); // released
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3)); // fwd WB
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3)); // lw x5
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3)); // reset while frozen
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // cleared

    // Initial reset; model starts empty.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clock);
    mp[0] = '0; mp[1] = '0; mcnt[0] = 0; mcnt[1] = 0;
    #1;
    chk("reset stall_f", a_stall_f, 0);
    chk("reset cnt", a_cnt, 0);
    chk("reset fwd1", a_f1, 0);
    @(negedge clock);

    // Directed table on the default configuration.
    foreach (tbl[i]) begin
      vec_t r = tbl[i];
      drive(r.v, r.rs1, r.rs2, r.u1, r.u2, r.rd, r.we, r.ld, r.st, r.redir, r.busy, r.rst);
      #1;
      chk($sformatf("row%0d stall_f", i), a_stall_f, r.e_stall);
      chk($sformatf("row%0d flush_id", i), a_flush_id, r.e_flush);
      chk($sformatf("row%0d bubble_ex", i), a_bubble_ex, r.e_bub);
      chk($sformatf("row%0d freeze", i), a_freeze, r.busy);
      chk($sformatf("row%0d fwd1", i), a_f1, r.e_f1);
      chk($sformatf("row%0d fwd2", i), a_f2, r.e_f2);
      chk($sformatf("row%0d cnt", i), a_cnt, r.e_cnt);
      step();
    end

    // DEPTH=4 / LOAD_STAGE=4: load feeding next instruction stalls two cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0); step();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    #1; chk("d4 stall cycle1", b_stall_f, 1); step();
    #1; chk("d4 stall cycle2", b_stall_f, 1); step();
    #1; chk("d4 released", b_stall_f, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("d4 fwd1 WB", b_f1, 4); chk("d4 cnt", b_cnt, 2); step();

    // Two more load-use pairs: 2-bit counter saturates at 3.
    for (int p = 0; p < 2; p++) begin
      drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0); step();
      drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0); step(); step(); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("d4 cnt saturated", b_cnt, 3); chk("d3 cnt", a_cnt, 3); step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit st = ($urandom_range(0, 5) == 0);
      bit ld = !st && ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 6) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), 1'($urandom), $urandom_range(0, 7), !st && ($urandom_range(0, 4) != 0),
            ld, st, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
